// File: rtl/alu_pkg.sv
// Shared types for the accumulator ALU: op codes and control states.
package alu_pkg;

   typedef enum logic [2:0] {
      OP_ADD  = 3'b000,
      OP_SUB  = 3'b001,
      OP_OR   = 3'b010,
      OP_XOR  = 3'b011,
      OP_AND  = 3'b100,
      OP_LOAD = 3'b101,
      OP_MUL  = 3'b110,
      OP_SHL  = 3'b111
   } alu_op_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_MUL  = 1'b1
   } alu_state_e;

endpackage

// File: rtl/alu_mul_seq.sv
// Shift-and-add unsigned multiplier with a fixed WIDTH-cycle latency.
// product_o is the running sum including the current step, so on the
// finish_o cycle it already holds the complete double-width product.
module alu_mul_seq #(
   parameter int unsigned WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start_i,
   input  logic [WIDTH-1:0]     mcand_i,
   input  logic [WIDTH-1:0]     mplier_i,
   output logic                 busy_o,
   output logic                 finish_o,
   output logic [2*WIDTH-1:0]   product_o
);

   localparam int unsigned CW = $clog2(WIDTH + 1);

   logic [2*WIDTH-1:0] mcand_q, mcand_d;
   logic [2*WIDTH-1:0] prod_q, prod_d;
   logic [WIDTH-1:0]   mplier_q, mplier_d;
   logic [CW-1:0]      count_q, count_d;
   logic [2*WIDTH-1:0] prod_step;

   assign busy_o    = (count_q != '0);
   assign finish_o  = (count_q == CW'(1));
   assign prod_step = prod_q + (mplier_q[0] ? mcand_q : '0);
   assign product_o = prod_step;

   // Load operands on start, otherwise advance one shift-add step while busy.
   always_comb begin
      mcand_d  = mcand_q;
      prod_d   = prod_q;
      mplier_d = mplier_q;
      count_d  = count_q;
      if (start_i) begin
         mcand_d  = {{WIDTH{1'b0}}, mcand_i};
         mplier_d = mplier_i;
         prod_d   = '0;
         count_d  = CW'(WIDTH);
      end else if (busy_o) begin
         prod_d   = prod_step;
         mcand_d  = mcand_q << 1;
         mplier_d = mplier_q >> 1;
         count_d  = count_q - CW'(1);
      end
   end

   // Datapath registers; reset aborts any multiply in progress.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mcand_q  <= '0;
         prod_q   <= '0;
         mplier_q <= '0;
         count_q  <= '0;
      end else begin
         mcand_q  <= mcand_d;
         prod_q   <= prod_d;
         mplier_q <= mplier_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/accum_alu.sv
// WIDTH-bit accumulator ALU with status flags, optional unsigned
// saturation and a valid/ready command port. MUL runs on alu_mul_seq.
module accum_alu
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH    = 8,
   parameter bit          SATURATE = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] operand,
   output logic [WIDTH-1:0] result,
   output logic             flag_zero,
   output logic             flag_carry,
   output logic             flag_ovf,
   output logic             done
);

   localparam logic [WIDTH-1:0] W_VEC = WIDTH'(WIDTH);

   alu_state_e         state_q, state_d;
   logic [WIDTH-1:0]   acc_q, acc_d;
   logic               zero_q, zero_d;
   logic               carry_q, carry_d;
   logic               ovf_q, ovf_d;
   logic               done_q, done_d;

   alu_op_e            op_e;
   logic               accept;
   logic               mul_start;
   logic               mul_busy;
   logic               mul_finish;
   logic [2*WIDTH-1:0] mul_prod;

   logic [WIDTH:0]     sum_w, diff_w;
   logic [WIDTH-1:0]   shamt;
   logic [2*WIDTH-1:0] shl_w;
   logic [WIDTH-1:0]   alu_res;
   logic               alu_c, alu_v;

   assign op_e      = alu_op_e'(op);
   assign in_ready  = (state_q == ST_IDLE) && !mul_busy;
   assign accept    = in_valid && in_ready;
   assign mul_start = accept && (op_e == OP_MUL);

   assign result     = acc_q;
   assign flag_zero  = zero_q;
   assign flag_carry = carry_q;
   assign flag_ovf   = ovf_q;
   assign done       = done_q;

   alu_mul_seq #(
      .WIDTH (WIDTH)
   ) u_mul (
      .clk       (clk),
      .reset     (reset),
      .start_i   (mul_start),
      .mcand_i   (acc_q),
      .mplier_i  (operand),
      .busy_o    (mul_busy),
      .finish_o  (mul_finish),
      .product_o (mul_prod)
   );

   // Single-cycle result and flags for every op except MUL.
   always_comb begin
      sum_w   = {1'b0, acc_q} + {1'b0, operand};
      diff_w  = {1'b0, acc_q} - {1'b0, operand};
      shamt   = operand % W_VEC;
      // Bit WIDTH of the widened shift is the last bit pushed out of acc.
      shl_w   = {{WIDTH{1'b0}}, acc_q} << shamt;
      alu_res = acc_q;
      alu_c   = 1'b0;
      alu_v   = 1'b0;
      case (op_e)
         OP_ADD: begin
            alu_c   = sum_w[WIDTH];
            alu_v   = (acc_q[WIDTH-1] == operand[WIDTH-1]) &&
                      (sum_w[WIDTH-1] != acc_q[WIDTH-1]);
            alu_res = (SATURATE && alu_c) ? '1 : sum_w[WIDTH-1:0];
         end
         OP_SUB: begin
            alu_c   = diff_w[WIDTH];
            alu_v   = (acc_q[WIDTH-1] != operand[WIDTH-1]) &&
                      (diff_w[WIDTH-1] != acc_q[WIDTH-1]);
            alu_res = (SATURATE && alu_c) ? '0 : diff_w[WIDTH-1:0];
         end
         OP_OR:   alu_res = acc_q | operand;
         OP_XOR:  alu_res = acc_q ^ operand;
         OP_AND:  alu_res = acc_q & operand;
         OP_LOAD: alu_res = operand;
         OP_SHL: begin
            alu_res = shl_w[WIDTH-1:0];
            alu_c   = shl_w[WIDTH];
         end
         default: alu_res = acc_q;
      endcase
   end

   // Control FSM: commit single-cycle ops on accept, MUL on sequencer finish.
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      zero_d  = zero_q;
      carry_d = carry_q;
      ovf_d   = ovf_q;
      done_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (mul_start) begin
               state_d = ST_MUL;
            end else if (accept) begin
               acc_d   = alu_res;
               zero_d  = (alu_res == '0);
               carry_d = alu_c;
               ovf_d   = alu_v;
               done_d  = 1'b1;
            end
         end
         ST_MUL: begin
            if (mul_finish) begin
               acc_d   = mul_prod[WIDTH-1:0];
               zero_d  = (mul_prod[WIDTH-1:0] == '0);
               carry_d = |mul_prod[2*WIDTH-1:WIDTH];
               ovf_d   = 1'b0;
               done_d  = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Accumulator, flag and state registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         acc_q   <= '0;
         zero_q  <= 1'b1;
         carry_q <= 1'b0;
         ovf_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         zero_q  <= zero_d;
         carry_q <= carry_d;
         ovf_q   <= ovf_d;
         done_q  <= done_d;
      end
   end

endmodule

// File: tb/tb_accum_alu.sv
// Directed bench for accum_alu: one wrapping and one saturating instance
// share the same command stream and are checked against hand-computed values.
module tb_accum_alu;
   import alu_pkg::*;

   localparam int unsigned W = 8;

   logic         clk = 1'b0;
   logic         reset;
   logic         in_valid;
   logic [2:0]   op;
   logic [W-1:0] operand;

   logic         rdy0, z0, c0, v0, d0;
   logic [W-1:0] r0;
   logic         rdy1, z1, c1, v1, d1;
   logic [W-1:0] r1;

   int n_vec = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   accum_alu #(.WIDTH(W), .SATURATE(1'b0)) u_wrap (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy0),
      .op(op), .operand(operand), .result(r0), .flag_zero(z0),
      .flag_carry(c0), .flag_ovf(v0), .done(d0)
   );

   accum_alu #(.WIDTH(W), .SATURATE(1'b1)) u_sat (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy1),
      .op(op), .operand(operand), .result(r1), .flag_zero(z1),
      .flag_carry(c1), .flag_ovf(v1), .done(d1)
   );

   typedef struct {
      logic [2:0]   op;
      logic [W-1:0] opd;
      logic [W-1:0] r;  logic z;  logic c;  logic v;
      logic [W-1:0] rs; logic zs; logic cs; logic vs;
   } vec_t;

   vec_t vt[21];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Both instances see the same value (non-saturating ops).
   task automatic chk_both(input string tag, input logic [W-1:0] r, input logic z,
                           input logic c, input logic v, input logic d, input logic rdy);
      chk({tag, " wrap result"}, r0, r);
      chk({tag, " wrap zero"},   z0, z);
      chk({tag, " wrap carry"},  c0, c);
      chk({tag, " wrap ovf"},    v0, v);
      chk({tag, " wrap done"},   d0, d);
      chk({tag, " wrap ready"},  rdy0, rdy);
      chk({tag, " sat result"},  r1, r);
      chk({tag, " sat zero"},    z1, z);
      chk({tag, " sat carry"},   c1, c);
      chk({tag, " sat ovf"},     v1, v);
      chk({tag, " sat done"},    d1, d);
      chk({tag, " sat ready"},   rdy1, rdy);
   endtask

   task automatic cmd(input logic [2:0] o, input logic [W-1:0] x);
      op = o; operand = x; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   // MUL from a known accumulator value: check busy window, latency and result.
   task automatic do_mul(input string tag, input logic [W-1:0] pre, input logic [W-1:0] m,
                         input logic [W-1:0] r, input logic z, input logic c);
      op = OP_MUL; operand = m; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk({tag, " ready low after accept"}, {rdy0, rdy1}, 2'b00);
      for (int unsigned i = 1; i < W; i++) begin
         @(posedge clk); #1;
         chk({tag, " busy ready/done"}, {rdy0, rdy1, d0, d1}, 4'b0000);
         chk({tag, " busy acc held"}, {r0, r1}, {pre, pre});
      end
      @(posedge clk); #1;
      chk_both({tag, " end"}, r, z, c, 1'b0, 1'b1, 1'b1);
      @(posedge clk); #1;
      chk({tag, " done single pulse"}, {d0, d1}, 2'b00);
   endtask

   initial begin
      vt[0]  = '{OP_LOAD, 8'd200, 8'd200, 0, 0, 0, 8'd200, 0, 0, 0};
      vt[1]  = '{OP_ADD,  8'd100, 8'd44,  0, 1, 0, 8'd255, 0, 1, 0};
      vt[2]  = '{OP_LOAD, 8'd100, 8'd100, 0, 0, 0, 8'd100, 0, 0, 0};
      vt[3]  = '{OP_ADD,  8'd100, 8'd200, 0, 0, 1, 8'd200, 0, 0, 1};
      vt[4]  = '{OP_LOAD, 8'd0,   8'd0,   1, 0, 0, 8'd0,   1, 0, 0};
      vt[5]  = '{OP_SUB,  8'd1,   8'd255, 0, 1, 0, 8'd0,   1, 1, 0};
      vt[6]  = '{OP_LOAD, 8'h81,  8'h81,  0, 0, 0, 8'h81,  0, 0, 0};
      vt[7]  = '{OP_SHL,  8'd1,   8'h02,  0, 1, 0, 8'h02,  0, 1, 0};
      vt[8]  = '{OP_SHL,  8'd9,   8'h04,  0, 0, 0, 8'h04,  0, 0, 0};
      vt[9]  = '{OP_LOAD, 8'h0F,  8'h0F,  0, 0, 0, 8'h0F,  0, 0, 0};
      vt[10] = '{OP_XOR,  8'hFF,  8'hF0,  0, 0, 0, 8'hF0,  0, 0, 0};
      vt[11] = '{OP_OR,   8'h0F,  8'hFF,  0, 0, 0, 8'hFF,  0, 0, 0};
      vt[12] = '{OP_AND,  8'h3C,  8'h3C,  0, 0, 0, 8'h3C,  0, 0, 0};
      vt[13] = '{OP_SUB,  8'h3C,  8'h00,  1, 0, 0, 8'h00,  1, 0, 0};
      vt[14] = '{OP_LOAD, 8'h80,  8'h80,  0, 0, 0, 8'h80,  0, 0, 0};
      vt[15] = '{OP_SUB,  8'h01,  8'h7F,  0, 0, 1, 8'h7F,  0, 0, 1};
      vt[16] = '{OP_SHL,  8'd0,   8'h7F,  0, 0, 0, 8'h7F,  0, 0, 0};
      vt[17] = '{OP_SHL,  8'd15,  8'h80,  0, 1, 0, 8'h80,  0, 1, 0};
      vt[18] = '{OP_LOAD, 8'h80,  8'h80,  0, 0, 0, 8'h80,  0, 0, 0};
      vt[19] = '{OP_ADD,  8'h80,  8'h00,  1, 1, 1, 8'hFF,  0, 1, 1};
      vt[20] = '{OP_ADD,  8'h01,  8'h01,  0, 0, 0, 8'hFF,  0, 1, 0};

      reset = 1'b1; in_valid = 1'b0; op = OP_ADD; operand = '0;
      #2;
      chk_both("reset before clock", 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      @(posedge clk); @(negedge clk);
      reset = 1'b0;

      // Back-to-back accepts: in_valid stays high, one command per edge.
      for (int i = 0; i < 21; i++) begin
         op = vt[i].op; operand = vt[i].opd; in_valid = 1'b1;
         @(posedge clk); #1;
         chk($sformatf("vec%0d wrap result", i), r0, vt[i].r);
         chk($sformatf("vec%0d wrap flags", i), {z0, c0, v0, d0}, {vt[i].z, vt[i].c, vt[i].v, 1'b1});
         chk($sformatf("vec%0d sat result", i), r1, vt[i].rs);
         chk($sformatf("vec%0d sat flags", i), {z1, c1, v1, d1}, {vt[i].zs, vt[i].cs, vt[i].vs, 1'b1});
         chk($sformatf("vec%0d ready", i), {rdy0, rdy1}, 2'b11);
      end
      in_valid = 1'b0;
      @(posedge clk); #1;
      chk("idle no done", {d0, d1}, 2'b00);

      cmd(OP_LOAD, 8'd13);
      do_mul("mul13x11", 8'd13, 8'd11, 8'd143, 1'b0, 1'b0);
      cmd(OP_LOAD, 8'd16);
      do_mul("mul16x16", 8'd16, 8'd16, 8'd0, 1'b1, 1'b1);

      // Reset three cycles into a multiply.
      cmd(OP_LOAD, 8'd7);
      op = OP_MUL; operand = 8'd3; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b1;
      #1;
      chk_both("reset mid-mul async", 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      @(posedge clk); @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         chk("aborted mul no done", {d0, d1, r0, r1}, {2'b00, 8'd0, 8'd0});
      end
      cmd(OP_ADD, 8'd5);
      chk_both("add5 after reset", 8'd5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

      // in_valid held high through a MUL busy window: ADD accepted once.
      op = OP_MUL; operand = 8'd3; in_valid = 1'b1;
      @(posedge clk); #1;
      op = OP_ADD; operand = 8'd5;
      for (int unsigned i = 1; i < W; i++) begin
         @(posedge clk); #1;
         chk("held busy", {rdy0, rdy1, d0, d1, r0, r1}, {4'b0000, 8'd5, 8'd5});
      end
      @(posedge clk); #1;
      chk_both("held mul end", 8'd15, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk_both("held add accepted", 8'd20, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      @(posedge clk); #1;
      chk_both("held add once", 8'd20, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/accum_alu.md
# accum_alu

Parametrised accumulator ALU: next generation of the team's 4-bit accumulator ALU, generalised to `WIDTH` bits with eight operations, status flags, an optional saturating mode and a valid/ready command interface. Arithmetic and logic ops complete in one cycle. MUL is a multi-cycle shift-and-add that back-pressures the command source. It sits between the command/input decode logic and the output pins, with `result` driven directly from the accumulator register.

## Interface
- `WIDTH`, 8: accumulator and operand width, ≥ 2.
- `SATURATE`, 0: 1 clamps unsigned ADD/SUB results instead of wrapping.
- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  one clock; reset is asynchronous and active-high.
- `in_valid`  in  1  command present.
- `in_ready`  out  1  block can accept a command.
- `op`  in  3  operation code, sampled on accept.
- `operand`  in  `WIDTH`  operand, sampled on accept.
- `result`  out  `WIDTH`  accumulator value.
- `flag_zero`  out  1  accumulator == 0.
- `flag_carry`  out  1  unsigned carry/borrow/overflow of last op.
- `flag_ovf`  out  1  signed overflow of last ADD/SUB.
- `done`  out  1  one-cycle pulse, coincident with the accumulator/flag update of a completed command.

## Operation
- Accept = `in_valid && in_ready` at a rising edge. No command is queued; `op`/`operand` only matter on the accept edge.
- Op codes:
  - 000 ADD: acc + operand.
  - 001 SUB: acc − operand.
  - 010 OR.
  - 011 XOR.
  - 100 AND.
  - 101 LOAD: acc ← operand.
  - 110 MUL: low `WIDTH` bits of acc × operand, unsigned.
  - 111 SHL: acc << (operand mod `WIDTH`).
- Flags are registered and update only when a command completes.
  - `flag_zero` = (new acc == 0).
  - `flag_carry`:
    - ADD: carry out.
    - SUB: borrow (operand > acc, unsigned).
    - MUL: any nonzero product bit above `WIDTH`−1.
    - SHL: last bit shifted out (0 if shift amount is 0).
    - Logic ops and LOAD: 0.
  - `flag_ovf`: two's-complement overflow for ADD/SUB, 0 for all other ops.
- `SATURATE`=1:
  - ADD with carry gives all-ones.
  - SUB with borrow gives 0.
  - Flags report the unclamped condition; `flag_zero` reflects the clamped acc.
  - Other ops are unaffected.
- FSM states and transitions:
  - IDLE: `in_ready`=1. Accepting a non-MUL op updates acc and flags at that edge and pulses `done`. Accepting MUL latches multiplicand=acc, multiplier=operand, product=0, count=`WIDTH`, then goes to MUL.
  - MUL: `in_ready`=0. Each edge: if multiplier[0], product += multiplicand; then multiplicand <<= 1, multiplier >>= 1, count −= 1. The edge that takes count to 0 writes acc and flags, pulses `done` and returns to IDLE.
  - MUL has no early termination; its latency is fixed.
- acc is unchanged while in MUL.

## Timing
- Reset values (async assert, all outputs): acc 0, `result` 0, `flag_zero` 1, `flag_carry` 0, `flag_ovf` 0, `done` 0, `in_ready` 1, FSM IDLE.
- Non-MUL op: accepted at edge N; `result`, flags and `done` are valid after edge N, i.e. latency 1. Back-to-back accepts every cycle are allowed.
- MUL: accepted at edge N.
  - `in_ready` is low for cycles N+1 … N+`WIDTH`.
  - acc, flags and `done` update at edge N+`WIDTH`.
  - `in_ready` returns to 1 after that edge.
  - Next accept is possible at edge N+`WIDTH`+1.
- `in_valid` held while `in_ready`=0: no effect; the command is accepted on the first ready edge.
- `reset` mid-MUL aborts the multiply; all state returns to reset values and no `done` is issued.
- Reset deassertion is synchronised externally; the first accept may occur on the first edge after deassertion.

## Structure
- `alu_pkg`:
  - `alu_op_e` enum for the 3-bit op codes.
  - `alu_state_e` enum (IDLE, MUL).
- Sub-module `alu_mul_seq`: shift-add datapath with registers multiplicand, multiplier, product (`WIDTH`+`WIDTH` bits for carry detection) and count. It has start/busy/finish ports and the same `clk`/`reset`.
- Top level holds the FSM, single-cycle datapath, saturation and flag registers.

## Test plan
All scenarios use `WIDTH`=8.
- Reset asserted mid-cycle → `result`=0, `flag_zero`=1, `in_ready`=1 immediately, without waiting for a clock edge.
- LOAD 200, ADD 100 → `result`=44, carry=1, ovf=0. Same with `SATURATE`=1 → `result`=255, carry=1.
- LOAD 100, ADD 100 → `result`=200, ovf=1, carry=0. LOAD 0, SUB 1 → `result`=255, carry=1, ovf=0. SATURATE=1 → `result`=0, zero=1.
- LOAD 13, MUL 11 → `in_ready` low 8 cycles, `done` on 8th edge, `result`=143, carry=0. LOAD 16, MUL 16 → `result`=0, zero=1, carry=1.
- LOAD 0x81, SHL 1 → 0x02, carry=1. SHL 9 → shift by 1. XOR 0xFF on 0x0F → 0xF0, carry=0.
- Reset pulse 3 cycles into MUL → no `done`, `result`=0, `in_ready`=1. Then ADD 5 → `result`=5, with `in_valid` held across the MUL busy window accepted exactly once.
